// File: rtl/mem_stage_lsu.sv
// MIPS memory-access stage: ALU pass-through, byte/half/word loads and stores over a
// req/ack data bus, load extension, misalignment and bus-timeout reporting.
//
// state | meaning
// IDLE  | ready; pass-through and misaligned ops complete here in one cycle
// BUS   | dm_req held with stable address/data, waiting for dm_ack or timeout
// DONE  | result pulse on out_valid, then back to IDLE
module mem_stage_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_sdata_i,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [DATA_W/8-1:0]   dm_be,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W-1:0]     dm_rdata,
  input  logic                  dm_ack,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [3:0]              r_op;
  logic [1:0]              r_lane;
  logic [REG_ADDR_W-1:0]   r_wd;
  logic                    r_wreg;
  logic                    r_dm_req, r_dm_we, r_out_valid, r_wreg_o, r_err;
  logic [ADDR_W-1:0]       r_dm_addr;
  logic [DATA_W/8-1:0]     r_dm_be;
  logic [DATA_W-1:0]       r_dm_wdata, r_wdata_o;
  logic [REG_ADDR_W-1:0]   r_wd_o;

  logic                    w_accept, w_is_load, w_is_store, w_is_mem, w_misalign, w_r_is_load;
  logic [DATA_W/8-1:0]     w_be;
  logic [DATA_W-1:0]       w_sdata, w_ldata;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_is_load   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
  assign w_is_store  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
  assign w_is_mem    = w_is_load || w_is_store;
  assign w_r_is_load = (r_op >= OP_LB) && (r_op <= OP_LW);
  assign w_misalign  = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH))
                        && mem_addr_i[0])
                    || (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));

  always_comb begin
    w_be    = '1;
    w_sdata = mem_sdata_i;
    case (mem_op_i)
      OP_SB: begin
        w_be    = (DATA_W/8)'(1) << mem_addr_i[1:0];
        w_sdata = {(DATA_W/8){mem_sdata_i[7:0]}};
      end
      OP_SH: begin
        w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_sdata = {(DATA_W/16){mem_sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched address bits; dm_rdata is only meaningful on ack.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dm_rdata[7:0];
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      default: w_byte = dm_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_op)
      OP_LB:   w_ldata = {{(DATA_W-8){w_byte[7]}}, w_byte};
      OP_LBU:  w_ldata = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LH:   w_ldata = {{(DATA_W-16){w_half[15]}}, w_half};
      OP_LHU:  w_ldata = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ldata = dm_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mem && !w_misalign) w_state_nxt = S_BUS;
      S_BUS:   if (dm_ack || (r_cnt == CNT_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;  r_op <= '0;  r_lane <= '0;  r_wd <= '0;  r_wreg <= 1'b0;
      r_dm_req <= 1'b0;  r_dm_we <= 1'b0;  r_dm_addr <= '0;  r_dm_be <= '0;  r_dm_wdata <= '0;
      r_out_valid <= 1'b0;  r_wd_o <= '0;  r_wreg_o <= 1'b0;  r_wdata_o <= '0;  r_err <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= mem_op_i;
          r_lane <= mem_addr_i[1:0];
          r_wd   <= wd_i;
          r_wreg <= wreg_i;
          r_cnt  <= '0;
          if (!w_is_mem) begin
            r_out_valid <= 1'b1;
            r_wd_o      <= wd_i;
            r_wreg_o    <= wreg_i;
            r_wdata_o   <= wdata_i;
          end else if (w_misalign) begin
            r_out_valid <= 1'b1;
            r_err       <= 1'b1;
            r_wd_o      <= wd_i;
            r_wreg_o    <= 1'b0;
          end else begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= w_is_store;
            r_dm_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            r_dm_be    <= w_be;
            r_dm_wdata <= w_sdata;
          end
        end
        S_BUS: begin
          if (dm_ack) begin
            r_dm_req    <= 1'b0;
            r_out_valid <= 1'b1;
            r_wd_o      <= r_wd;
            r_wreg_o    <= w_r_is_load && r_wreg;
            r_wdata_o   <= w_ldata;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_dm_req    <= 1'b0;
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
              r_wd_o      <= r_wd;
              r_wreg_o    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign stall_o   = !in_ready;
  assign dm_req    = r_dm_req;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_be     = r_dm_be;
  assign dm_wdata  = r_dm_wdata;
  assign out_valid = r_out_valid;
  assign wd_o      = r_wd_o;
  assign wreg_o    = r_wreg_o;
  assign wdata_o   = r_wdata_o;
  assign err_o     = r_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus random ops against an arithmetic
// model of lane selection, extension, byte enables and store replication.
module tb_mem_stage_lsu;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wreg_i, dm_req, dm_we, dm_ack;
  logic        out_valid, wreg_o, err_o, stall_o;
  logic [4:0]  wd_i, wd_o;
  logic [3:0]  mem_op_i, dm_be;
  logic [31:0] wdata_i, mem_addr_i, mem_sdata_i, dm_addr, dm_wdata, dm_rdata, wdata_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          mem, mis, we, wr;
    logic [3:0]  be;
    logic [31:0] bwdata, res;
  } exp_t;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .out_valid(out_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .err_o(err_o), .stall_o(stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [31:0] wdata, input bit wreg);
    exp_t e;
    int size, k;
    longint v, m;
    e = '{default: 0};
    k = int'(addr % 32'd4);
    if (op < 1 || op > 8) begin
      e.res = wdata;
      e.wr  = wreg;
      return e;
    end
    e.mem = 1;
    size  = (op <= 2 || op == 6) ? 1 : (op <= 4 || op == 7) ? 2 : 4;
    e.mis = (k % size) != 0;
    m     = (longint'(1) << (8 * size)) - 1;
    e.we  = (op >= 6);
    if (e.we) begin
      e.be     = 4'(((1 << size) - 1) << k);
      v        = longint'(sdata) & m;
      e.bwdata = 32'(v * ((size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'h1));
      e.wr     = 0;
    end else begin
      e.be  = 4'hF;
      v     = (longint'(sdata) * 0 + longint'(rdata) >> (8 * k)) & m;
      if ((op == 1 || op == 3) && v > (m >> 1)) v = v - (m + 1);
      e.res = 32'(v);
      e.wr  = wreg;
    end
    if (e.mis) e.wr = 0;
    return e;
  endfunction

  // Issues one op at a negedge and follows it to completion; d = BUS cycles before ack, <0 = never.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [4:0] wd, input bit wreg, input int d);
    exp_t e;
    int stall, limit;
    bit to;
    e = model(op, addr, sdata, rdata, wdata, wreg);
    stall = 0;
    chk("ready_before", in_ready, 1);
    in_valid = 1; mem_op_i = 4'(op); mem_addr_i = addr; mem_sdata_i = sdata;
    wdata_i = wdata; wd_i = wd; wreg_i = wreg;
    @(posedge clk); @(negedge clk);
    in_valid = 0; mem_op_i = 4'($urandom); mem_addr_i = $urandom; mem_sdata_i = $urandom;
    wdata_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'($urandom);
    if (!e.mem || e.mis) begin
      chk("pass_valid", out_valid, 1);
      chk("pass_err", err_o, e.mis);
      chk("pass_wreg", wreg_o, e.wr);
      chk("pass_noreq", {dm_req, stall_o}, 0);
      if (!e.mis) begin
        chk("pass_wd", wd_o, wd);
        chk("pass_wdata", wdata_o, e.res);
      end
    end else begin
      to    = (d < 0 || d >= MAX_WAIT);
      limit = to ? MAX_WAIT - 1 : d;
      for (int i = 0; i <= limit; i++) begin
        if (stall_o) stall++;
        chk("bus_ctl", {dm_req, dm_we, dm_be, dm_addr}, {1'b1, e.we, e.be, addr & 32'hFFFF_FFFC});
        if (e.we) chk("bus_wdata", dm_wdata, e.bwdata);
        chk("bus_novalid", {out_valid, err_o}, 0);
        dm_ack   = (i == d);
        dm_rdata = (i == d) ? rdata : $urandom;
        @(posedge clk); @(negedge clk);
      end
      dm_ack = 0;
      if (stall_o) stall++;
      chk("done_valid", out_valid, 1);
      chk("done_req", dm_req, 0);
      chk("done_err", err_o, to);
      chk("done_wreg", wreg_o, to ? 1'b0 : e.wr);
      chk("done_wd", wd_o, wd);
      if (!to && !e.we) chk("load_data", wdata_o, e.res);
      @(posedge clk); @(negedge clk);
      chk("stall_cycles", stall, limit + 2);
      if (to) begin
        dm_ack = 1; dm_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        dm_ack = 0;
        chk("late_ack", {out_valid, dm_req}, 0);
      end
    end
    @(posedge clk); @(negedge clk);
    chk("idle_after", {out_valid, err_o, in_ready}, 3'b001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d;
    logic [4:0]  exp_wd;
    int op, d;
    logic [31:0] addr;
    rst = 1; in_valid = 0; dm_ack = 0; dm_rdata = 0; wd_i = 0; wreg_i = 0;
    wdata_i = 0; mem_op_i = 0; mem_addr_i = 0; mem_sdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {out_valid, err_o, wreg_o, wd_o, dm_req, dm_we, dm_be, stall_o}, 0);
    chk("rst_data", {wdata_o, dm_wdata}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_ready", in_ready, 1);
    rst = 0;
    @(posedge clk); @(negedge clk);

    do_op(0, 32'h0, 32'h0, 32'h12345678, 32'h0, 5'd3, 1'b1, 0);

    exp_d = 0; exp_wd = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", wdata_o, exp_d);
        chk("b2b_wd", wd_o, exp_wd);
      end
      if (k < 4) begin
        in_valid = 1; mem_op_i = (k == 3) ? 4'd12 : 4'd0; wdata_i = $urandom;
        wd_i = 5'(k + 3); wreg_i = 1; exp_d = wdata_i; exp_wd = wd_i;
      end else in_valid = 0;
      @(posedge clk); @(negedge clk);
    end
    chk("b2b_end", out_valid, 0);

    do_op(1, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 5'd5, 1'b1, 1);
    do_op(2, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 5'd5, 1'b1, 1);
    do_op(7, 32'h202, 32'h0000_BEEF, 32'h0, 32'h0, 5'd6, 1'b1, 0);
    do_op(5, 32'h201, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 0);
    do_op(5, 32'h300, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, -1);
    do_op(3, 32'h402, 32'h0, 32'h0, 32'h8001_1234, 5'd9, 1'b1, MAX_WAIT - 1);

    in_valid = 1; mem_op_i = 4'd5; mem_addr_i = 32'h400; wd_i = 5'd10; wreg_i = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("rstbus_req", dm_req, 1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    chk("rstbus_out", {dm_req, dm_we, dm_be, out_valid, err_o, wreg_o, wd_o, stall_o}, 0);
    chk("rstbus_data", {dm_addr, wdata_o}, 0);
    rst = 0; dm_ack = 1; dm_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    dm_ack = 0;
    chk("rstbus_ack", {out_valid, dm_req}, 0);
    @(posedge clk); @(negedge clk);
    chk("rstbus_after", {out_valid, in_ready}, 2'b01);

    for (int n = 0; n < 150; n++) begin
      op   = $urandom_range(0, 15);
      addr = $urandom;
      d    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      do_op(op, addr, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
